regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Owns the single write port of the 32x32 MIPS register file.
- After reset, or on request, sweeps every register to its init value.
- Then shares the port between pipeline writeback (priority) and a host/debug writer, using a req/ack handshake and starvation relief.
- Sits between the writeback stage / debug controller and the register file write inputs.

Parameters:
DATA_WIDTH, 32, register width
ADDR_WIDTH, 5, register address width
NUM_REGS, 32, registers swept during init
INIT_R1, -30, init value of register 1 (two's complement, DATA_WIDTH bits)
INIT_R2, 56, init value of register 2
STARVE_LIMIT, 8, consecutive unserved host-request cycles before a forced host slot (>=2)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
init_start  in  1  single-cycle pulse: re-run init sweep
wb_enable  in  1  writeback write request, one-cycle, no handshake
wb_address  in  ADDR_WIDTH  writeback destination
wb_data  in  DATA_WIDTH  writeback data
wb_stall  out  1  pipeline must hold wb_enable=0 in this cycle
host_req  in  1  host write request, level, held until ack
host_address  in  ADDR_WIDTH  host destination, stable while req
host_data  in  DATA_WIDTH  host data, stable while req
host_ack  out  1  one-cycle pulse: host write issued
rf_write_enable  out  1  to register file write_enable
rf_write_address  out  ADDR_WIDTH  to register file write_address
rf_write_data  out  DATA_WIDTH  to register file write_data_in
init_busy  out  1  init sweep in progress; pipeline stalled

Behaviour:
- All outputs registered. Reset (reset=0): state=INIT, sweep counter=0, starve counter=0, init_busy=1, rf_write_enable=0, rf_write_address=0, rf_write_data=0, host_ack=0, wb_stall=0.
- FSM states: INIT, RUN.
- INIT:
  - Edge k+1 after reset release presents rf_write_enable=1, address k, data = k, except register 1 = INIT_R1 and register 2 = INIT_R2. k runs 0..NUM_REGS-1.
  - init_busy stays high through the cycle presenting NUM_REGS-1, then drops; next state RUN.
  - wb_enable during INIT is a protocol violation: dropped, no write.
  - host_req is not served in INIT; ack is deferred until RUN.
  - init_start during INIT is ignored.
- RUN, per edge, priority order:
  1. init_start=1: go to INIT, counter=0, init_busy=1 next cycle; the current-cycle wb write is still issued.
  2. wb_enable=1: issue the wb write next cycle; the host loses this cycle.
  3. host_req=1, host_ack currently 0, and wb_stall currently 0 or wb_enable=0: issue the host write; host_ack=1 on the same cycle as rf_write_*.
  4. Otherwise rf_write_enable=0.
- Latency: request sampled at edge N, rf_write_* valid in cycle N+1 (one cycle).
- Host masking: host_req is ignored in a cycle where host_ack=1, so a held request is never written twice. A new request needs req sampled high on a later edge.
- Address 0 writes (wb or host) are dropped (rf_write_enable=0). The host is still acked.
- Starvation:
  - Starve counter increments each RUN cycle host_req=1 and the host is not granted; it clears on grant or when req=0.
  - When the count reaches STARVE_LIMIT-1, wb_stall=1 for exactly one cycle.
  - In that cycle wb_enable is guaranteed 0 by the pipeline, and the host is granted.
- Simultaneous wb and host to the same address: wb wins; the host write follows later and overwrites.
- Reset mid-INIT or mid-RUN aborts immediately and restarts the sweep from 0; a pending host request is not acked.

Decomposition:
- Shared package regfile_pkg holds:
  - the DATA_WIDTH/ADDR_WIDTH defaults;
  - the state encoding (INIT=1'b0, RUN=1'b1);
  - the init-value function (index -> init data, with the INIT_R1/INIT_R2 overrides), also used by the register file reset path.
- One natural sub-module: regfile_init_sweeper (counter plus init data generator, done flag).

Test Plan:
- Release reset, no requests -> 32 writes at cycles 1..32: addr1=0xFFFFFFE2, addr2=0x38, addr31=0x1F. init_busy falls at cycle 33.
- RUN, wb_enable with addr 5/data 0xDEADBEEF and host_req with addr 6/data 0x1234 on the same edge -> cycle N+1 writes addr 5. Cycle N+2 writes addr 6 with host_ack=1. Exactly one host write.
- wb_enable held high continuously with host_req=1, STARVE_LIMIT=8 -> wb_stall pulses one cycle after 7 lost cycles; the host write is issued in that slot; no lost wb writes.
- host_req with addr 0 -> host_ack pulse, rf_write_enable=0.
- init_start mid-RUN with a pending host_req -> full 32-register sweep. The host is acked only after init_busy drops, and its data is not overwritten by the sweep.
- reset asserted at sweep index 10 -> outputs reset asynchronously; the sweep restarts at index 0 after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register file write path.
//   - default data/address widths and register count
//   - arbiter state encoding
//   - init_value(): per-register reset contents, shared by the init sweep
//     and the register file reset path
package regfile_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int ADDR_WIDTH_DEF = 5;
   localparam int NUM_REGS_DEF   = 32;
   localparam int INIT_R1_DEF    = -30;
   localparam int INIT_R2_DEF    = 56;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } arb_state_t;

   // Register k holds k after init, except r1/r2 which carry signed
   // overrides. Returned 64 bits wide, sign-extended; callers size-cast.
   function automatic logic [63:0] init_value(input logic [31:0] idx,
                                              input int r1, input int r2);
      logic [63:0] v;
      v = {32'd0, idx};
      if (idx == 32'd1) v = {{32{r1[31]}}, r1};
      if (idx == 32'd2) v = {{32{r2[31]}}, r2};
      return v;
   endfunction

endpackage

// File: rtl/regfile_init_sweeper.sv
// Init sweep generator: walks register indices 0..NUM_REGS-1 and supplies
// the init data for each.
//   clock, reset   : clock, async active-low reset (counter -> 0)
//   restart        : force the counter back to 0
//   advance        : step to the next index (wraps to 0 after the last)
//   sweep_address  : current index
//   sweep_data     : init value for the current index
//   sweep_last     : current index is the final register
module regfile_init_sweeper
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int NUM_REGS   = NUM_REGS_DEF,
   parameter int INIT_R1    = INIT_R1_DEF,
   parameter int INIT_R2    = INIT_R2_DEF
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  restart,
   input  logic                  advance,
   output logic [ADDR_WIDTH-1:0] sweep_address,
   output logic [DATA_WIDTH-1:0] sweep_data,
   output logic                  sweep_last
);

   logic [ADDR_WIDTH-1:0] count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)       count <= '0;
      else if (restart) count <= '0;
      else if (advance) count <= sweep_last ? '0 : count + 1'b1;
   end

   assign sweep_last    = (count == ADDR_WIDTH'(NUM_REGS - 1));
   assign sweep_address = count;
   assign sweep_data    = DATA_WIDTH'(init_value(32'(count), INIT_R1, INIT_R2));

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owner of the register file write port. Sweeps all registers to their
// init values after reset or init_start, then shares the port between
// writeback (priority) and a host writer with req/ack and starvation relief.
//   clock, reset           : clock, async active-low reset
//   init_start             : pulse, re-run the init sweep (ignored in INIT)
//   wb_enable/address/data : one-cycle writeback write
//   wb_stall               : pipeline must keep wb_enable low this cycle
//   host_req/address/data  : level request, held until host_ack
//   host_ack               : one-cycle pulse, coincides with the host write
//   rf_write_*             : register file write port
//   init_busy              : sweep in progress
module regfile_write_arbiter
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
   parameter int NUM_REGS     = NUM_REGS_DEF,
   parameter int INIT_R1      = INIT_R1_DEF,
   parameter int INIT_R2      = INIT_R2_DEF,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  init_start,
   input  logic                  wb_enable,
   input  logic [ADDR_WIDTH-1:0] wb_address,
   input  logic [DATA_WIDTH-1:0] wb_data,
   output logic                  wb_stall,
   input  logic                  host_req,
   input  logic [ADDR_WIDTH-1:0] host_address,
   input  logic [DATA_WIDTH-1:0] host_data,
   output logic                  host_ack,
   output logic                  rf_write_enable,
   output logic [ADDR_WIDTH-1:0] rf_write_address,
   output logic [DATA_WIDTH-1:0] rf_write_data,
   output logic                  init_busy
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   arb_state_t            state, state_nxt;
   logic [SW-1:0]         starve, starve_nxt;
   logic                  we_nxt, ack_nxt, stall_nxt, busy_nxt;
   logic [ADDR_WIDTH-1:0] addr_nxt;
   logic [DATA_WIDTH-1:0] data_nxt;
   logic                  sweep_restart, sweep_last, host_take, host_grant;
   logic [ADDR_WIDTH-1:0] sweep_address;
   logic [DATA_WIDTH-1:0] sweep_data;

   regfile_init_sweeper #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .INIT_R1    (INIT_R1),
      .INIT_R2    (INIT_R2)
   ) u_sweeper (
      .clock         (clock),
      .reset         (reset),
      .restart       (sweep_restart),
      .advance       (state == ST_INIT),
      .sweep_address (sweep_address),
      .sweep_data    (sweep_data),
      .sweep_last    (sweep_last)
   );

   // A request still high during its ack cycle is the one just served.
   assign host_take = host_req && !host_ack;

   always_comb begin
      state_nxt     = state;
      we_nxt        = 1'b0;
      addr_nxt      = rf_write_address;
      data_nxt      = rf_write_data;
      ack_nxt       = 1'b0;
      stall_nxt     = 1'b0;
      busy_nxt      = 1'b0;
      starve_nxt    = starve;
      sweep_restart = 1'b0;
      host_grant    = 1'b0;
      unique case (state)
         ST_INIT: begin
            // wb and host requests are not served while sweeping
            we_nxt   = 1'b1;
            addr_nxt = sweep_address;
            data_nxt = sweep_data;
            busy_nxt = 1'b1;
            if (sweep_last) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (wb_enable) begin
               we_nxt   = (wb_address != '0);
               addr_nxt = wb_address;
               data_nxt = wb_data;
            end else if (host_take && !init_start) begin
               host_grant = 1'b1;
               we_nxt     = (host_address != '0);
               addr_nxt   = host_address;
               data_nxt   = host_data;
               ack_nxt    = 1'b1;
            end
            if (init_start) begin
               state_nxt     = ST_INIT;
               busy_nxt      = 1'b1;
               sweep_restart = 1'b1;
               starve_nxt    = '0;
            end else begin
               starve_nxt = (host_take && !host_grant) ? starve + 1'b1 : '0;
               // one-cycle stall hands the next edge to the waiting host
               stall_nxt  = (starve_nxt == SW'(STARVE_LIMIT - 1));
            end
         end
         default: state_nxt = ST_INIT;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state            <= ST_INIT;
         starve           <= '0;
         init_busy        <= 1'b1;
         rf_write_enable  <= 1'b0;
         rf_write_address <= '0;
         rf_write_data    <= '0;
         host_ack         <= 1'b0;
         wb_stall         <= 1'b0;
      end else begin
         state            <= state_nxt;
         starve           <= starve_nxt;
         init_busy        <= busy_nxt;
         rf_write_enable  <= we_nxt;
         rf_write_address <= addr_nxt;
         rf_write_data    <= data_nxt;
         host_ack         <= ack_nxt;
         wb_stall         <= stall_nxt;
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 32;
   localparam int LIMIT = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          init_start = 1'b0;
   logic          wb_enable = 1'b0;
   logic [AW-1:0] wb_address = '0;
   logic [DW-1:0] wb_data = '0;
   logic          host_req = 1'b0;
   logic [AW-1:0] host_address = '0;
   logic [DW-1:0] host_data = '0;
   logic          wb_stall, host_ack, rf_write_enable, init_busy;
   logic [AW-1:0] rf_write_address;
   logic [DW-1:0] rf_write_data;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   regfile_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clock            (clock),
      .reset            (reset),
      .init_start       (init_start),
      .wb_enable        (wb_enable),
      .wb_address       (wb_address),
      .wb_data          (wb_data),
      .wb_stall         (wb_stall),
      .host_req         (host_req),
      .host_address     (host_address),
      .host_data        (host_data),
      .host_ack         (host_ack),
      .rf_write_enable  (rf_write_enable),
      .rf_write_address (rf_write_address),
      .rf_write_data    (rf_write_data),
      .init_busy        (init_busy)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // register k -> k, r1 = -30, r2 = 56
   function automatic logic [DW-1:0] sweep_val(input int k);
      if (k == 1) return 32'hFFFF_FFE2;
      if (k == 2) return 32'h0000_0038;
      return DW'(k);
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({init_busy, rf_write_enable, host_ack, wb_stall, rf_write_address, rf_write_data}
          !== {1'b1, 1'b0, 1'b0, 1'b0, AW'(0), DW'(0)}) begin
         errors++;
         $display("FAIL reset_values: got busy=%b we=%b ack=%b stall=%b a=%0d d=%h want 1 0 0 0 0 0",
                  init_busy, rf_write_enable, host_ack, wb_stall, rf_write_address, rf_write_data);
      end
   endtask

   // Sweep after release; wb during INIT is dropped, host deferred to RUN.
   task automatic test_init_sweep();
      @(negedge clock);
      reset = 1'b1;
      wb_enable = 1'b1; wb_address = 5'd7; wb_data = 32'h77;
      host_req = 1'b1; host_address = 5'd4; host_data = 32'h4444;
      for (int k = 0; k < NR; k++) begin
         step();
         checks++;
         if ({rf_write_enable, init_busy, host_ack, rf_write_address, rf_write_data}
             !== {1'b1, 1'b1, 1'b0, AW'(k), sweep_val(k)}) begin
            errors++;
            $display("FAIL sweep_%0d: got we=%b busy=%b ack=%b a=%0d d=%h want 1 1 0 %0d %h",
                     k, rf_write_enable, init_busy, host_ack, rf_write_address, rf_write_data,
                     k, sweep_val(k));
         end
      end
      wb_enable = 1'b0;
      step();
      checks++;
      if ({init_busy, rf_write_enable, host_ack, rf_write_address, rf_write_data}
          !== {1'b0, 1'b1, 1'b1, 5'd4, 32'h4444}) begin
         errors++;
         $display("FAIL sweep_end_host: got busy=%b we=%b ack=%b a=%0d d=%h want 0 1 1 4 4444",
                  init_busy, rf_write_enable, host_ack, rf_write_address, rf_write_data);
      end
      host_req = 1'b0;
      step();
      checks++;
      if ({rf_write_enable, host_ack} !== 2'b00) begin
         errors++;
         $display("FAIL sweep_idle: got we=%b ack=%b want 0 0", rf_write_enable, host_ack);
      end
   endtask

   task automatic test_wb_host_same_edge();
      wb_enable = 1'b1; wb_address = 5'd5; wb_data = 32'hDEAD_BEEF;
      host_req = 1'b1; host_address = 5'd6; host_data = 32'h1234;
      step();
      wb_enable = 1'b0;
      checks++;
      if ({rf_write_enable, host_ack, rf_write_address, rf_write_data}
          !== {1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF}) begin
         errors++;
         $display("FAIL same_edge_wb: got we=%b ack=%b a=%0d d=%h want 1 0 5 deadbeef",
                  rf_write_enable, host_ack, rf_write_address, rf_write_data);
      end
      step();
      checks++;
      if ({rf_write_enable, host_ack, rf_write_address, rf_write_data}
          !== {1'b1, 1'b1, 5'd6, 32'h1234}) begin
         errors++;
         $display("FAIL same_edge_host: got we=%b ack=%b a=%0d d=%h want 1 1 6 1234",
                  rf_write_enable, host_ack, rf_write_address, rf_write_data);
      end
      step();  // request still held during ack cycle: must not be written again
      checks++;
      if ({rf_write_enable, host_ack} !== 2'b00) begin
         errors++;
         $display("FAIL host_mask: got we=%b ack=%b want 0 0", rf_write_enable, host_ack);
      end
      host_req = 1'b0;
      step();
   endtask

   task automatic test_addr0();
      host_req = 1'b1; host_address = 5'd0; host_data = 32'hABCD;
      step();
      host_req = 1'b0;
      checks++;
      if ({rf_write_enable, host_ack} !== 2'b01) begin
         errors++;
         $display("FAIL host_addr0: got we=%b ack=%b want 0 1", rf_write_enable, host_ack);
      end
      wb_enable = 1'b1; wb_address = 5'd0; wb_data = 32'h1111;
      step();
      wb_enable = 1'b0;
      checks++;
      if ({rf_write_enable, host_ack} !== 2'b00) begin
         errors++;
         $display("FAIL wb_addr0: got we=%b ack=%b want 0 0", rf_write_enable, host_ack);
      end
      step();
   endtask

   task automatic test_starvation();
      int            lost, stalls, ack_cycle;
      logic          pend_wb, exp_host;
      logic [AW-1:0] pa;
      logic [DW-1:0] pd;
      lost = 0; stalls = 0; ack_cycle = -1;
      host_req = 1'b1; host_address = 5'd9; host_data = 32'hCAFE_0009;
      wb_enable = 1'b1;
      wb_address = AW'($urandom_range(1, NR - 1)); wb_data = $urandom;
      for (int c = 0; c < 16; c++) begin
         pend_wb  = wb_enable; pa = wb_address; pd = wb_data;
         exp_host = host_req && !host_ack && !wb_enable;
         lost     = (host_req && !host_ack && wb_enable) ? lost + 1 : 0;
         step();
         checks++;
         if (pend_wb) begin
            if ({rf_write_enable, host_ack, rf_write_address, rf_write_data} !== {1'b1, 1'b0, pa, pd}) begin
               errors++;
               $display("FAIL starve_wb_%0d: got we=%b ack=%b a=%0d d=%h want 1 0 %0d %h",
                        c, rf_write_enable, host_ack, rf_write_address, rf_write_data, pa, pd);
            end
         end else if (exp_host) begin
            if ({rf_write_enable, host_ack, rf_write_address, rf_write_data}
                !== {1'b1, 1'b1, 5'd9, 32'hCAFE_0009}) begin
               errors++;
               $display("FAIL starve_host_%0d: got we=%b ack=%b a=%0d d=%h want 1 1 9 cafe0009",
                        c, rf_write_enable, host_ack, rf_write_address, rf_write_data);
            end
         end else if ({rf_write_enable, host_ack} !== 2'b00) begin
            errors++;
            $display("FAIL starve_idle_%0d: got we=%b ack=%b want 0 0", c, rf_write_enable, host_ack);
         end
         checks++;
         if (wb_stall !== (lost == LIMIT - 1)) begin
            errors++;
            $display("FAIL starve_stall_%0d: got %b want %b", c, wb_stall, (lost == LIMIT - 1));
         end
         if (wb_stall) stalls++;
         if (host_ack) begin ack_cycle = c; host_req = 1'b0; end
         wb_enable = !wb_stall;
         wb_address = AW'($urandom_range(1, NR - 1)); wb_data = $urandom;
      end
      wb_enable = 1'b0;
      checks++;
      if (stalls != 1 || ack_cycle != LIMIT - 1) begin
         errors++;
         $display("FAIL starve_summary: got stalls=%0d ack_cycle=%0d want 1 %0d", stalls, ack_cycle, LIMIT - 1);
      end
      step();
   endtask

   task automatic test_init_restart();
      host_req = 1'b1; host_address = 5'd3; host_data = 32'h55AA;
      init_start = 1'b1;
      step();
      init_start = 1'b0;
      checks++;
      if ({init_busy, rf_write_enable, host_ack} !== 3'b100) begin
         errors++;
         $display("FAIL restart_first: got busy=%b we=%b ack=%b want 1 0 0", init_busy, rf_write_enable, host_ack);
      end
      for (int k = 0; k < NR; k++) begin
         step();
         checks++;
         if ({rf_write_enable, init_busy, host_ack, rf_write_address, rf_write_data}
             !== {1'b1, 1'b1, 1'b0, AW'(k), sweep_val(k)}) begin
            errors++;
            $display("FAIL restart_sweep_%0d: got we=%b busy=%b ack=%b a=%0d d=%h want 1 1 0 %0d %h",
                     k, rf_write_enable, init_busy, host_ack, rf_write_address, rf_write_data,
                     k, sweep_val(k));
         end
      end
      step();
      checks++;
      if ({init_busy, rf_write_enable, host_ack, rf_write_address, rf_write_data}
          !== {1'b0, 1'b1, 1'b1, 5'd3, 32'h55AA}) begin
         errors++;
         $display("FAIL restart_host: got busy=%b we=%b ack=%b a=%0d d=%h want 0 1 1 3 55aa",
                  init_busy, rf_write_enable, host_ack, rf_write_address, rf_write_data);
      end
      host_req = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_sweep();
      init_start = 1'b1;
      step();
      init_start = 1'b0;
      for (int k = 0; k <= 10; k++) step();
      checks++;
      if (rf_write_address !== 5'd10) begin
         errors++;
         $display("FAIL midreset_index: got %0d want 10", rf_write_address);
      end
      host_req = 1'b1; host_address = 5'd12; host_data = 32'h12;
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({init_busy, rf_write_enable, host_ack, wb_stall, rf_write_address, rf_write_data}
          !== {1'b1, 1'b0, 1'b0, 1'b0, AW'(0), DW'(0)}) begin
         errors++;
         $display("FAIL midreset_async: got busy=%b we=%b ack=%b stall=%b a=%0d d=%h want 1 0 0 0 0 0",
                  init_busy, rf_write_enable, host_ack, wb_stall, rf_write_address, rf_write_data);
      end
      host_req = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      step();
      checks++;
      if ({rf_write_enable, init_busy, rf_write_address, rf_write_data} !== {1'b1, 1'b1, AW'(0), DW'(0)}) begin
         errors++;
         $display("FAIL midreset_restart: got we=%b busy=%b a=%0d d=%h want 1 1 0 0",
                  rf_write_enable, init_busy, rf_write_address, rf_write_data);
      end
      for (int i = 0; i < 40 && init_busy; i++) step();
      checks++;
      if (init_busy !== 1'b0) begin
         errors++;
         $display("FAIL midreset_done: init_busy still %b after bound", init_busy);
      end
   endtask

   // Random traffic against a rule-level model: wb issues next cycle,
   // else an unmasked host request is granted and acked, lost host cycles
   // accumulate until a one-cycle stall.
   task automatic test_random();
      int            lost;
      logic          ack_m, stall_m, exp_we, exp_ack;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      lost = 0; ack_m = 1'b0; stall_m = 1'b0;
      ea = '0; ed = '0;
      for (int c = 0; c < 400; c++) begin
         if (!host_req && $urandom_range(0, 99) < 35) begin
            host_req = 1'b1; host_address = AW'($urandom); host_data = $urandom;
         end
         wb_enable  = !stall_m && ($urandom_range(0, 99) < 65);
         wb_address = AW'($urandom); wb_data = $urandom;
         exp_we = 1'b0; exp_ack = 1'b0;
         if (wb_enable) begin
            exp_we = (wb_address != 0); ea = wb_address; ed = wb_data;
         end else if (host_req && !ack_m) begin
            exp_we = (host_address != 0); ea = host_address; ed = host_data; exp_ack = 1'b1;
         end
         lost    = (host_req && !ack_m && wb_enable) ? lost + 1 : 0;
         stall_m = (lost == LIMIT - 1);
         ack_m   = exp_ack;
         step();
         checks++;
         if ({rf_write_enable, host_ack, wb_stall} !== {exp_we, exp_ack, stall_m}) begin
            errors++;
            $display("FAIL rand_ctrl_%0d: got we=%b ack=%b stall=%b want %b %b %b",
                     c, rf_write_enable, host_ack, wb_stall, exp_we, exp_ack, stall_m);
         end
         if (exp_we) begin
            checks++;
            if ({rf_write_address, rf_write_data} !== {ea, ed}) begin
               errors++;
               $display("FAIL rand_data_%0d: got a=%0d d=%h want a=%0d d=%h",
                        c, rf_write_address, rf_write_data, ea, ed);
            end
         end
         if (exp_ack) host_req = 1'b0;
      end
      wb_enable = 1'b0; host_req = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_init_sweep();
      test_wb_host_same_edge();
      test_addr0();
      test_starvation();
      test_init_restart();
      test_reset_mid_sweep();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
